// File: rtl/omsp_hmac_responder.sv
// omsp_hmac_responder
//   Hash-core side of the HMAC word handshake. Collects 16-bit message words
//   from the HMAC control FSM into RATE_WORDS blocks and hands each block to an
//   external permutation core. It then pads and finalises the message, and
//   serves the digest one 16-bit word per advance request.
//
// Ports
//   clk, reset_n          core clock, asynchronous active-low reset
//   hmac_reset            synchronous clear from the control FSM
//   hmac_start_continue   one-cycle request strobe
//   hmac_data_available   1: request carries data_in, 0: finalise / advance
//   hmac_data_is_long     1: full word, 0: final short byte in data_in[7:0]
//   data_in               big-endian message word
//   hmac_busy             request in progress (registered)
//   hmac_out              current digest word (registered)
//   proto_err             sticky protocol violation flag
//   core_clear            permutation state clear (combinational, = hmac_reset)
//   core_start            one-cycle absorb pulse
//   core_block            block to absorb, word 0 in the MSBs
//   core_done             permutation finished pulse
//   core_digest           permutation output, word 0 in the MSBs
module omsp_hmac_responder #(
  parameter int RATE_WORDS   = 4,
  parameter int DIGEST_WORDS = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      hmac_reset,
  input  logic                      hmac_start_continue,
  input  logic                      hmac_data_available,
  input  logic                      hmac_data_is_long,
  input  logic [15:0]               data_in,
  output logic                      hmac_busy,
  output logic [15:0]               hmac_out,
  output logic                      proto_err,
  output logic                      core_clear,
  output logic                      core_start,
  output logic [16*RATE_WORDS-1:0]  core_block,
  input  logic                      core_done,
  input  logic [16*DIGEST_WORDS-1:0] core_digest
);

  localparam int FILL_W = $clog2(RATE_WORDS + 1);
  localparam int IDX_W  = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;

  typedef enum logic [2:0] {
    ST_ABSORB,
    ST_ACK,
    ST_PERM,
    ST_PAD,
    ST_SQUEEZE,
    ST_NEXT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [FILL_W-1:0] fill;
  logic              short_seen;
  logic              final_blk;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_inc;
  logic [15:0]       block_buf [RATE_WORDS];
  logic [15:0]       digest    [DIGEST_WORDS];

  logic              busy_state;
  logic              last_slot;
  logic              absorb_word;
  logic              busy_nxt;
  logic              start_nxt;
  logic              err_set;

  assign core_clear  = hmac_reset;
  assign busy_state  = state inside {ST_ACK, ST_PAD, ST_PERM, ST_NEXT};
  assign last_slot   = (fill == FILL_W'(RATE_WORDS - 1));
  assign idx_inc     = (idx == IDX_W'(DIGEST_WORDS - 1)) ? '0 : idx + IDX_W'(1);
  // Once the short byte has been absorbed the message is closed to further data.
  assign absorb_word = hmac_start_continue && (state == ST_ABSORB) &&
                       hmac_data_available && !short_seen;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_ABSORB;
    end else if (hmac_reset) begin
      state <= ST_ABSORB;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ABSORB: begin
        if (hmac_start_continue) begin
          if (!hmac_data_available)  state_nxt = ST_PAD;
          else if (absorb_word && last_slot) state_nxt = ST_PERM;
          else                       state_nxt = ST_ACK;
        end
      end
      ST_ACK:     state_nxt = ST_ABSORB;
      ST_PAD:     state_nxt = ST_PERM;
      ST_PERM: begin
        if (core_done) state_nxt = final_blk ? ST_SQUEEZE : ST_ABSORB;
      end
      ST_SQUEEZE: begin
        if (hmac_start_continue && !hmac_data_available) state_nxt = ST_NEXT;
      end
      ST_NEXT:    state_nxt = ST_SQUEEZE;
      default:    state_nxt = ST_ABSORB;
    endcase
  end

  // Output decode: busy and core_start are registered from the next state so
  // busy is already high in the cycle right after an accepted strobe.
  always_comb begin
    busy_nxt  = state_nxt inside {ST_ACK, ST_PAD, ST_PERM, ST_NEXT};
    start_nxt = (state_nxt == ST_PERM) && (state != ST_PERM);
    err_set   = 1'b0;
    if (hmac_start_continue) begin
      if (busy_state)                                               err_set = 1'b1;
      else if ((state == ST_SQUEEZE) && hmac_data_available)        err_set = 1'b1;
      else if ((state == ST_ABSORB) && hmac_data_available && short_seen) err_set = 1'b1;
    end
  end

  always_comb begin
    core_block = '0;
    for (int w = 0; w < RATE_WORDS; w++) begin
      core_block[16*(RATE_WORDS-1-w) +: 16] = block_buf[w];
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill       <= '0;
      short_seen <= 1'b0;
      final_blk  <= 1'b0;
      idx        <= '0;
      hmac_busy  <= 1'b0;
      hmac_out   <= '0;
      core_start <= 1'b0;
      proto_err  <= 1'b0;
      for (int w = 0; w < RATE_WORDS; w++)   block_buf[w] <= '0;
      for (int w = 0; w < DIGEST_WORDS; w++) digest[w]    <= '0;
    end else if (hmac_reset) begin
      fill       <= '0;
      short_seen <= 1'b0;
      final_blk  <= 1'b0;
      idx        <= '0;
      hmac_busy  <= 1'b0;
      hmac_out   <= '0;
      core_start <= 1'b0;
      proto_err  <= 1'b0;
      for (int w = 0; w < RATE_WORDS; w++)   block_buf[w] <= '0;
      for (int w = 0; w < DIGEST_WORDS; w++) digest[w]    <= '0;
    end else begin
      hmac_busy  <= busy_nxt;
      core_start <= start_nxt;
      if (err_set) proto_err <= 1'b1;

      case (state)
        ST_ABSORB: begin
          if (absorb_word) begin
            for (int w = 0; w < RATE_WORDS; w++) begin
              if (fill == FILL_W'(w)) begin
                block_buf[w] <= hmac_data_is_long ? data_in : {data_in[7:0], 8'h80};
              end
            end
            fill <= fill + FILL_W'(1);
            if (!hmac_data_is_long) short_seen <= 1'b1;
          end
          if (hmac_start_continue && !hmac_data_available) final_blk <= 1'b1;
        end
        ST_PAD: begin
          // The short byte already carries its own 0x80 terminator.
          if (!short_seen) begin
            for (int w = 0; w < RATE_WORDS; w++) begin
              if (fill == FILL_W'(w)) block_buf[w] <= 16'h8000;
            end
          end
        end
        ST_PERM: begin
          if (core_done) begin
            fill <= '0;
            for (int w = 0; w < RATE_WORDS; w++) block_buf[w] <= '0;
            if (final_blk) begin
              for (int w = 0; w < DIGEST_WORDS; w++) begin
                digest[w] <= core_digest[16*(DIGEST_WORDS-1-w) +: 16];
              end
              hmac_out <= core_digest[16*DIGEST_WORDS-1 -: 16];
              idx      <= '0;
            end
          end
        end
        ST_NEXT: begin
          idx <= idx_inc;
          for (int w = 0; w < DIGEST_WORDS; w++) begin
            if (idx_inc == IDX_W'(w)) hmac_out <= digest[w];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_omsp_hmac_responder.sv
module tb_omsp_hmac_responder;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         hmac_reset = 1'b0;
  logic         hmac_start_continue = 1'b0;
  logic         hmac_data_available = 1'b0;
  logic         hmac_data_is_long = 1'b0;
  logic [15:0]  data_in = 16'h0;
  logic         hmac_busy;
  logic [15:0]  hmac_out;
  logic         proto_err;
  logic         core_clear;
  logic         core_start;
  logic [63:0]  core_block;
  logic         core_done = 1'b0;
  logic [127:0] core_digest = 128'h0A01_0B02_0C03_0D04_0E05_0F06_1007_1108;

  logic [15:0]  exp_dig [8] = '{16'h0A01, 16'h0B02, 16'h0C03, 16'h0D04,
                                16'h0E05, 16'h0F06, 16'h1007, 16'h1108};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  omsp_hmac_responder #(.RATE_WORDS(4), .DIGEST_WORDS(8)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .hmac_reset          (hmac_reset),
    .hmac_start_continue (hmac_start_continue),
    .hmac_data_available (hmac_data_available),
    .hmac_data_is_long   (hmac_data_is_long),
    .data_in             (data_in),
    .hmac_busy           (hmac_busy),
    .hmac_out            (hmac_out),
    .proto_err           (proto_err),
    .core_clear          (core_clear),
    .core_start          (core_start),
    .core_block          (core_block),
    .core_done           (core_done),
    .core_digest         (core_digest)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Strobe driven after a falling edge; returns at the falling edge right
  // after the rising edge that sampled it.
  task automatic strobe(input logic avail, input logic is_long, input logic [15:0] d);
    @(negedge clk);
    hmac_start_continue = 1'b1;
    hmac_data_available = avail;
    hmac_data_is_long   = is_long;
    data_in             = d;
    @(negedge clk);
    hmac_start_continue = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  task automatic pulse_hreset();
    @(negedge clk);
    hmac_reset = 1'b1;
    #1;
    chk("core_clear_hi", 64'(core_clear), 64'd1);
    @(negedge clk);
    hmac_reset = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy",  64'(hmac_busy),  64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_out",   64'(hmac_out),   64'd0);
    chk("rst_err",   64'(proto_err),  64'd0);
    chk("rst_start", 64'(core_start), 64'd0);
    chk("rst_block", core_block,      64'd0);
    chk("rst_clear", 64'(core_clear), 64'd0);

    // 1: two long words, finalise
    strobe(1'b1, 1'b1, 16'h1234);
    chk("t1_ack_busy", 64'(hmac_busy), 64'd1);
    @(negedge clk);
    chk("t1_idle_busy", 64'(hmac_busy), 64'd0);
    strobe(1'b1, 1'b1, 16'h5678);
    @(negedge clk);
    strobe(1'b0, 1'b0, 16'h0);
    chk("t1_pad_busy",  64'(hmac_busy),  64'd1);
    chk("t1_pad_start", 64'(core_start), 64'd0);
    @(negedge clk);
    chk("t1_start", 64'(core_start), 64'd1);
    chk("t1_block", core_block, 64'h1234_5678_8000_0000);
    @(negedge clk);
    chk("t1_start_once", 64'(core_start), 64'd0);
    chk("t1_perm_busy",  64'(hmac_busy),  64'd1);
    pulse_done();
    chk("t1_sq_busy",  64'(hmac_busy), 64'd0);
    chk("t1_sq_out",   64'(hmac_out),  64'(exp_dig[0]));
    chk("t1_sq_block", core_block,     64'd0);

    // 4: walk the digest and wrap
    for (int i = 0; i < 8; i++) begin
      strobe(1'b0, 1'b0, 16'h0);
      chk($sformatf("t4_busy_hi_%0d", i), 64'(hmac_busy), 64'd1);
      @(negedge clk);
      chk($sformatf("t4_busy_lo_%0d", i), 64'(hmac_busy), 64'd0);
      chk($sformatf("t4_out_%0d", i), 64'(hmac_out), 64'(exp_dig[(i + 1) % 8]));
    end

    // 6a: data strobe in SQUEEZE
    strobe(1'b1, 1'b1, 16'h7777);
    chk("t6_sq_err",  64'(proto_err), 64'd1);
    chk("t6_sq_out",  64'(hmac_out),  64'(exp_dig[0]));
    chk("t6_sq_busy", 64'(hmac_busy), 64'd0);
    pulse_hreset();
    chk("hr_err", 64'(proto_err), 64'd0);
    chk("hr_out", 64'(hmac_out),  64'd0);

    // 2: four words fill a block, finalise pads a whole block
    strobe(1'b1, 1'b1, 16'hAAAA); @(negedge clk);
    strobe(1'b1, 1'b1, 16'hBBBB); @(negedge clk);
    strobe(1'b1, 1'b1, 16'hCCCC); @(negedge clk);
    strobe(1'b1, 1'b1, 16'hDDDD);
    chk("t2_start", 64'(core_start), 64'd1);
    chk("t2_block", core_block, 64'hAAAA_BBBB_CCCC_DDDD);
    repeat (3) @(negedge clk);
    chk("t2_busy_wait", 64'(hmac_busy), 64'd1);
    pulse_done();
    chk("t2_busy_lo", 64'(hmac_busy), 64'd0);
    chk("t2_out_idle", 64'(hmac_out), 64'd0);
    strobe(1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk("t2_start2", 64'(core_start), 64'd1);
    chk("t2_block2", core_block, 64'h8000_0000_0000_0000);
    pulse_done();
    chk("t2_sq_out", 64'(hmac_out), 64'(exp_dig[0]));
    pulse_hreset();

    // 3: short byte then finalise; 6b: strobe while busy
    strobe(1'b1, 1'b0, 16'hFF01);
    @(negedge clk);
    chk("t3_block_short", core_block, 64'h0180_0000_0000_0000);
    strobe(1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk("t3_start", 64'(core_start), 64'd1);
    chk("t3_block", core_block, 64'h0180_0000_0000_0000);
    strobe(1'b1, 1'b1, 16'h9999);
    chk("t6_busy_err",   64'(proto_err), 64'd1);
    chk("t6_busy_block", core_block, 64'h0180_0000_0000_0000);
    pulse_done();
    chk("t3_sq_out", 64'(hmac_out),  64'(exp_dig[0]));
    chk("t6_sticky", 64'(proto_err), 64'd1);
    pulse_hreset();
    chk("t6_err_clr", 64'(proto_err), 64'd0);

    // 6c: word after short byte is dropped
    strobe(1'b1, 1'b0, 16'h0001);
    @(negedge clk);
    strobe(1'b1, 1'b1, 16'h5555);
    chk("t6_drop_err",   64'(proto_err), 64'd1);
    chk("t6_drop_busy",  64'(hmac_busy), 64'd1);
    chk("t6_drop_block", core_block, 64'h0180_0000_0000_0000);
    @(negedge clk);
    pulse_hreset();

    // 5: hmac_reset during PERM, stray core_done ignored
    strobe(1'b1, 1'b1, 16'h1111); @(negedge clk);
    strobe(1'b1, 1'b1, 16'h2222); @(negedge clk);
    strobe(1'b1, 1'b1, 16'h3333); @(negedge clk);
    strobe(1'b1, 1'b1, 16'h4444);
    chk("t5_perm_busy", 64'(hmac_busy), 64'd1);
    pulse_hreset();
    chk("t5_busy",  64'(hmac_busy),  64'd0);
    chk("t5_start", 64'(core_start), 64'd0);
    chk("t5_block", core_block,      64'd0);
    pulse_done();
    chk("t5_done_busy", 64'(hmac_busy), 64'd0);
    chk("t5_done_out",  64'(hmac_out),  64'd0);
    chk("t5_done_err",  64'(proto_err), 64'd0);
    strobe(1'b1, 1'b1, 16'h4242);
    chk("t5_absorb_busy",  64'(hmac_busy),  64'd1);
    chk("t5_absorb_start", 64'(core_start), 64'd0);
    chk("t5_absorb_block", core_block, 64'h4242_0000_0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
